key_pulse_gen: RTL
==================

KEY_PULSE_GEN -- requirements
Module: key_pulse_gen

Interface
REQ-001 Parameter N_KEYS, default 3: number of independent push-button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a press or a release (1 ms at 50 MHz); legal range 1 or more.
REQ-003 Parameter REPEAT_DELAY, default 25000000: cycles a key stays held after acceptance before the first auto-repeat pulse; legal range 1 or more.
REQ-004 Parameter REPEAT_PERIOD, default 5000000: cycles between subsequent auto-repeat pulses; legal range 1 or more.
REQ-005 Parameter REPEAT_EN, default 1: 1 enables auto-repeat; 0 gives one pulse per press.
REQ-006 clk  input  1  single system clock; all logic is on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 key_n  input  N_KEYS  raw, asynchronous, active-low buttons (0 = pressed).
REQ-009 pulse  output  N_KEYS  registered one-cycle event strobe per key, consumed by inc/dec/clear logic.
REQ-010 level  output  N_KEYS  registered debounced pressed state per key (1 = held).

Function
REQ-011 Each key_n bit passes through a two-flop synchronizer before any other use; the synchronizer output is "sync".
REQ-012 Each channel is an independent FSM with states IDLE, PRESS_DB, HELD, REPEAT and RELEASE_DB.
REQ-013 IDLE: level=0; sync pressed moves to PRESS_DB with the stable counter cleared.
REQ-014 PRESS_DB: the counter increments while sync is pressed; any released sample returns to IDLE with the counter cleared and no pulse.
REQ-015 PRESS_DB to HELD occurs when the counter reaches DEBOUNCE_CYCLES consecutive pressed samples; pulse=1 for exactly that one cycle and level=1 from that cycle on.
REQ-016 Press latency: with key_n held low continuously, pulse is high in the cycle after exactly DEBOUNCE_CYCLES+2 rising edges following the first edge that samples key_n low.
REQ-017 HELD, REPEAT_EN=1: after REPEAT_DELAY cycles still held, pulse=1 for one cycle and the FSM enters REPEAT.
REQ-018 REPEAT: pulse=1 for one cycle every REPEAT_PERIOD cycles while held.
REQ-019 HELD, REPEAT_EN=0: no further pulses are issued.
REQ-020 In HELD or REPEAT, sync released moves to RELEASE_DB with the counter cleared.
REQ-021 RELEASE_DB: DEBOUNCE_CYCLES consecutive released samples move to IDLE with level=0 and no pulse.
REQ-022 RELEASE_DB: any pressed sample returns to HELD with the repeat timer restarted and no pulse.
REQ-023 Counter widths: each counter is $clog2 of its maximum value plus 1, and counters saturate, never wrap.
REQ-024 A single shared timer per channel serves both debounce and repeat and is cleared on every state change.
REQ-025 Channels are fully independent: simultaneous presses on any keys each produce their own pulses in the same cycle where timing coincides, with no priority or masking.
REQ-026 pulse is never high for two consecutive cycles on one channel, for any parameter value of 1 or more.

Reset
REQ-027 While rst=1, all FSMs go to IDLE, all counters clear, synchronizer flops load 1 (released), and pulse and level are 0.
REQ-028 Reset asserted mid-operation (any state) takes effect on the next edge.
REQ-029 A key held through the deassertion of reset re-debounces from IDLE and produces a fresh pulse after the REQ-016 latency.

Structure
REQ-030 A shared package key_pkg holds the FSM state enumeration (5 states, 3-bit encoding) and the default timing constants.
REQ-031 One sub-module, key_channel (synchronizer, FSM and timer for one key), is instantiated N_KEYS times in a generate loop.
REQ-032 The top level contains only the generate loop and port concatenation.

Verification
REQ-033 Bench parameters are DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3 and REPEAT_EN=1.
REQ-034 Clean press: key_n[0] held low 8 cycles -> exactly one pulse[0] at edge 6 after the low sample; level[0]=1 from that edge on.
REQ-035 Bounce: key_n[1] low 3 cycles, high 1, low 3, then high -> no pulse[1]; level[1] stays 0.
REQ-036 Auto-repeat: key_n[0] low 30 cycles -> pulses at edges 6, 16, 19, 22, 25 and 28; then high -> level[0] falls 6 edges after release with no pulse.
REQ-037 Simultaneous: key_n[0] and key_n[2] go low on the same edge -> pulse[0] and pulse[2] both high on the same cycle; pulse[1] stays 0.
REQ-038 Reset mid-hold: rst=1 for 1 cycle while in REPEAT with the key still low -> outputs 0 next cycle; a fresh pulse follows 6 edges after rst deasserts.
REQ-039 REPEAT_EN=0: key held 30 cycles -> exactly one pulse.

Source files
------------

// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_pkg
// Description : Shared FSM state encoding and default timing for the
//               push-button pulse generator.
// Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRESS_DB   = 3'd1,
        ST_HELD       = 3'd2,
        ST_REPEAT     = 3'd3,
        ST_RELEASE_DB = 3'd4
    } key_state_t;

    localparam int unsigned c_DEF_N_KEYS          = 3;
    localparam int unsigned c_DEF_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned c_DEF_REPEAT_DELAY    = 25000000;
    localparam int unsigned c_DEF_REPEAT_PERIOD   = 5000000;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_channel.sv
`default_nettype none
// ============================================================================
// Module      : key_channel
// Description : One push-button channel: synchronizer, debounce/repeat FSM
//               and a shared saturating timer.
// Revision    : 1.0 - initial release
// ============================================================================
module key_channel
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = c_DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = c_DEF_REPEAT_PERIOD,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_pulse,
    output logic o_level
);

    // A delay or period of 1 would put two pulses on adjacent cycles.
    localparam int unsigned c_DELAY   = max2(REPEAT_DELAY, 2);
    localparam int unsigned c_PERIOD  = max2(REPEAT_PERIOD, 2);
    localparam int unsigned c_CNT_MAX = max2(DEBOUNCE_CYCLES, max2(c_DELAY, c_PERIOD));
    localparam int unsigned CW        = $clog2(c_CNT_MAX) + 1;

    localparam logic [CW-1:0] c_DB_CNT     = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] c_DELAY_CNT  = CW'(c_DELAY);
    localparam logic [CW-1:0] c_PERIOD_CNT = CW'(c_PERIOD);
    localparam logic [CW-1:0] c_CNT_ONE    = CW'(1);

    logic          r_sync1;
    logic          r_sync2;
    key_state_t    r_state;
    key_state_t    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic          r_pulse;
    logic          w_pulse_nxt;
    logic          r_level;
    logic          w_level_nxt;
    logic          w_pressed;

    assign w_pressed = ~r_sync2;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : (r_cnt + c_CNT_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_pulse_nxt;
            r_level <= w_level_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_inc;
        w_pulse_nxt = 1'b0;
        w_level_nxt = r_level;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
                if (w_pressed) begin
                    w_state_nxt = ST_PRESS_DB;
                end
            end
            ST_PRESS_DB: begin
                if (!w_pressed) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_inc == c_DB_CNT) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                    w_pulse_nxt = 1'b1;
                    w_level_nxt = 1'b1;
                end
            end
            ST_HELD: begin
                if (!w_pressed) begin
                    w_state_nxt = ST_RELEASE_DB;
                    w_cnt_nxt   = '0;
                end else if (REPEAT_EN && (w_cnt_inc == c_DELAY_CNT)) begin
                    w_state_nxt = ST_REPEAT;
                    w_cnt_nxt   = '0;
                    w_pulse_nxt = 1'b1;
                end
            end
            ST_REPEAT: begin
                if (!w_pressed) begin
                    w_state_nxt = ST_RELEASE_DB;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_inc == c_PERIOD_CNT) begin
                    w_cnt_nxt   = '0;
                    w_pulse_nxt = 1'b1;
                end
            end
            ST_RELEASE_DB: begin
                if (w_pressed) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_inc == c_DB_CNT) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign o_pulse = r_pulse;
    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/key_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : key_pulse_gen
// Description : N_KEYS independent debounced push-button pulse generators
//               with optional auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module key_pulse_gen
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS          = c_DEF_N_KEYS,
    parameter int unsigned DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = c_DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = c_DEF_REPEAT_PERIOD,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] pulse,
    output logic [N_KEYS-1:0] level
);

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_EN)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .i_key_n (key_n[gi]),
            .o_pulse (pulse[gi]),
            .o_level (level[gi])
        );
    end

endmodule
`default_nettype wire
